// File: rtl/riscv_core_trap_sequencer_if.sv
// Request/CSR/redirect bundle between the decode stage and the trap sequencer.
// Handshake: a request is taken on a rising edge when i_trap_valid=1, at least one flag is set and o_trap_busy=0; any other request is dropped, never queued.
interface riscv_core_trap_sequencer_if #(
  parameter int XLEN = 64
);
  logic            i_trap_valid;
  logic            i_trap_ecall;
  logic            i_trap_ebreak;
  logic            i_trap_mret;
  logic [XLEN-1:0] i_trap_pc;
  logic [XLEN-1:0] i_trap_mtvec;
  logic [XLEN-1:0] i_trap_mepc;
  logic [XLEN-1:0] i_trap_mstatus;
  logic            i_trap_pipe_empty;
  logic            o_trap_stall;
  logic            o_trap_flush;
  logic            o_trap_csr_we;
  logic [11:0]     o_trap_csr_addr;
  logic [XLEN-1:0] o_trap_csr_wdata;
  logic            o_trap_pc_sel;
  logic [XLEN-1:0] o_trap_pc_target;
  logic            o_trap_busy;
  logic [2:0]      dbg_state;

  modport master (
    output i_trap_valid, i_trap_ecall, i_trap_ebreak, i_trap_mret, i_trap_pc,
           i_trap_mtvec, i_trap_mepc, i_trap_mstatus, i_trap_pipe_empty,
    input  o_trap_stall, o_trap_flush, o_trap_csr_we, o_trap_csr_addr,
           o_trap_csr_wdata, o_trap_pc_sel, o_trap_pc_target, o_trap_busy, dbg_state
  );

  modport slave (
    input  i_trap_valid, i_trap_ecall, i_trap_ebreak, i_trap_mret, i_trap_pc,
           i_trap_mtvec, i_trap_mepc, i_trap_mstatus, i_trap_pipe_empty,
    output o_trap_stall, o_trap_flush, o_trap_csr_we, o_trap_csr_addr,
           o_trap_csr_wdata, o_trap_pc_sel, o_trap_pc_target, o_trap_busy, dbg_state
  );
endinterface

// File: rtl/riscv_core_trap_sequencer.sv
// Machine-mode trap entry / mret sequencer: drains the pipe, writes mepc/mcause/mstatus
// one CSR per cycle, then redirects the PC for a single cycle.
module riscv_core_trap_sequencer #(
  parameter int XLEN = 64
) (
  input logic                           i_clk,
  input logic                           i_rst,
  riscv_core_trap_sequencer_if.slave    bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DRAIN     = 3'd1;
  localparam logic [2:0] S_WR_EPC    = 3'd2;
  localparam logic [2:0] S_WR_CAUSE  = 3'd3;
  localparam logic [2:0] S_WR_STATUS = 3'd4;
  localparam logic [2:0] S_REDIRECT  = 3'd5;

  localparam logic [1:0] K_NONE   = 2'd0;
  localparam logic [1:0] K_ECALL  = 2'd1;
  localparam logic [1:0] K_EBREAK = 2'd2;
  localparam logic [1:0] K_MRET   = 2'd3;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  logic [2:0]      state;
  logic [1:0]      kind;
  logic [XLEN-1:0] cap_pc;
  logic            req;
  logic            unused_bits;

  assign req         = bus.i_trap_valid &
                       (bus.i_trap_ecall | bus.i_trap_ebreak | bus.i_trap_mret);
  assign unused_bits = ^{bus.i_trap_mtvec[1:0], bus.i_trap_mepc[0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      kind   <= K_NONE;
      cap_pc <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            // ebreak outranks ecall, which outranks mret
            if (bus.i_trap_ebreak)     kind <= K_EBREAK;
            else if (bus.i_trap_ecall) kind <= K_ECALL;
            else                       kind <= K_MRET;
            cap_pc <= bus.i_trap_pc;
            state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.i_trap_pipe_empty)
            state <= (kind == K_MRET) ? S_WR_STATUS : S_WR_EPC;
        end
        S_WR_EPC:    state <= S_WR_CAUSE;
        S_WR_CAUSE:  state <= S_WR_STATUS;
        S_WR_STATUS: state <= S_REDIRECT;
        S_REDIRECT:  state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  // CSR values are read live in the state that consumes them, not at capture.
  always_comb begin
    logic [XLEN-1:0] ms;
    ms                   = bus.i_trap_mstatus;
    bus.o_trap_stall     = (state != S_IDLE);
    bus.o_trap_busy      = (state != S_IDLE);
    bus.o_trap_flush     = (state == S_DRAIN) || (state == S_REDIRECT);
    bus.o_trap_csr_we    = 1'b0;
    bus.o_trap_csr_addr  = '0;
    bus.o_trap_csr_wdata = '0;
    bus.o_trap_pc_sel    = 1'b0;
    bus.o_trap_pc_target = '0;
    bus.dbg_state        = state;
    case (state)
      S_WR_EPC: begin
        bus.o_trap_csr_we    = 1'b1;
        bus.o_trap_csr_addr  = A_MEPC;
        bus.o_trap_csr_wdata = {cap_pc[XLEN-1:1], 1'b0};
      end
      S_WR_CAUSE: begin
        bus.o_trap_csr_we    = 1'b1;
        bus.o_trap_csr_addr  = A_MCAUSE;
        bus.o_trap_csr_wdata = {{(XLEN-4){1'b0}}, (kind == K_EBREAK) ? 4'd3 : 4'd11};
      end
      S_WR_STATUS: begin
        if (kind == K_MRET) begin
          ms[3] = bus.i_trap_mstatus[7];
          ms[7] = 1'b1;
        end else begin
          ms[7] = bus.i_trap_mstatus[3];
          ms[3] = 1'b0;
        end
        ms[12:11]            = 2'b11;
        bus.o_trap_csr_we    = 1'b1;
        bus.o_trap_csr_addr  = A_MSTATUS;
        bus.o_trap_csr_wdata = ms;
      end
      S_REDIRECT: begin
        bus.o_trap_pc_sel    = 1'b1;
        bus.o_trap_pc_target = (kind == K_MRET) ? {bus.i_trap_mepc[XLEN-1:1], 1'b0}
                                                : {bus.i_trap_mtvec[XLEN-1:2], 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_riscv_core_trap_sequencer.sv
// Bench for riscv_core_trap_sequencer: scenario tasks push expected CSR writes and redirects,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_riscv_core_trap_sequencer;
  localparam int XLEN = 64;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [12+XLEN-1:0] exp_q[$];
  logic [XLEN-1:0]    exp_pc_q[$];

  riscv_core_trap_sequencer_if #(.XLEN(XLEN)) bus ();

  riscv_core_trap_sequencer #(.XLEN(XLEN)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor
  always @(negedge clk) begin
    logic [12+XLEN-1:0] e;
    logic [XLEN-1:0]    p;
    if (!rst) begin
      vectors++;
      if (bus.o_trap_csr_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL csr_unexpected got addr=%h data=%h required no write",
                   bus.o_trap_csr_addr, bus.o_trap_csr_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({bus.o_trap_csr_addr, bus.o_trap_csr_wdata} !== e) begin
            miscompares++;
            $display("FAIL csr_write got addr=%h data=%h required addr=%h data=%h",
                     bus.o_trap_csr_addr, bus.o_trap_csr_wdata, e[12+XLEN-1:XLEN], e[XLEN-1:0]);
          end
        end
      end else if (bus.o_trap_csr_addr !== 12'h0 || bus.o_trap_csr_wdata !== '0) begin
        miscompares++;
        $display("FAIL csr_idle_zero got addr=%h data=%h required 0",
                 bus.o_trap_csr_addr, bus.o_trap_csr_wdata);
      end
      vectors++;
      if (bus.o_trap_pc_sel === 1'b1) begin
        if (exp_pc_q.size() == 0) begin
          miscompares++;
          $display("FAIL redirect_unexpected got target=%h required none", bus.o_trap_pc_target);
        end else begin
          p = exp_pc_q.pop_front();
          if (bus.o_trap_pc_target !== p) begin
            miscompares++;
            $display("FAIL redirect_target got %h required %h", bus.o_trap_pc_target, p);
          end
        end
      end else if (bus.o_trap_pc_target !== '0) begin
        miscompares++;
        $display("FAIL target_idle_zero got %h required 0", bus.o_trap_pc_target);
      end
      vectors++;
      if (bus.o_trap_stall !== bus.o_trap_busy) begin
        miscompares++;
        $display("FAIL stall_vs_busy got stall=%b busy=%b required equal",
                 bus.o_trap_stall, bus.o_trap_busy);
      end
    end
  end

  // driver tasks
  task automatic clear_req();
    bus.i_trap_valid  = 1'b0;
    bus.i_trap_ecall  = 1'b0;
    bus.i_trap_ebreak = 1'b0;
    bus.i_trap_mret   = 1'b0;
  endtask

  task automatic set_csrs(input logic [XLEN-1:0] mtvec, input logic [XLEN-1:0] mepc,
                          input logic [XLEN-1:0] mstatus);
    @(negedge clk);
    bus.i_trap_mtvec   = mtvec;
    bus.i_trap_mepc    = mepc;
    bus.i_trap_mstatus = mstatus;
  endtask

  // drives one request, optionally holds pipe_empty low and/or injects an ecall while busy
  task automatic run_req(input bit ec, input bit eb, input bit mr, input logic [XLEN-1:0] pc,
                         input int lat, input int drain, input bit intrude, input string name);
    int got;
    got = -1;
    @(negedge clk);
    bus.i_trap_pipe_empty = (drain == 0);
    bus.i_trap_valid  = 1'b1;
    bus.i_trap_ecall  = ec;
    bus.i_trap_ebreak = eb;
    bus.i_trap_mret   = mr;
    bus.i_trap_pc     = pc;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        clear_req();
        vectors++;
        if (bus.o_trap_busy !== 1'b1 || bus.o_trap_flush !== 1'b1) begin
          miscompares++;
          $display("FAIL %s_accept got busy=%b flush=%b required 1 1", name,
                   bus.o_trap_busy, bus.o_trap_flush);
        end
      end
      if (n <= drain) begin
        vectors++;
        if (bus.o_trap_stall !== 1'b1 || bus.o_trap_flush !== 1'b1 || bus.o_trap_csr_we !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_drain cycle %0d got stall=%b flush=%b we=%b required 1 1 0", name, n,
                   bus.o_trap_stall, bus.o_trap_flush, bus.o_trap_csr_we);
        end
        if (n == drain) bus.i_trap_pipe_empty = 1'b1;
      end
      if (intrude && n == 2) begin
        bus.i_trap_valid = 1'b1;
        bus.i_trap_ecall = 1'b1;
        bus.i_trap_pc    = 64'h0000_0000_0000_7770;
      end
      if (intrude && n == 3) clear_req();
      if (bus.o_trap_pc_sel === 1'b1 && got < 0) begin
        got = n;
        vectors++;
        if (bus.o_trap_flush !== 1'b1) begin
          miscompares++;
          $display("FAIL %s_redirect_flush got %b required 1", name, bus.o_trap_flush);
        end
      end
      if (bus.o_trap_busy === 1'b0) break;
    end
    vectors++;
    if (got != lat) begin
      miscompares++;
      $display("FAIL %s_latency got %0d required %0d", name, got, lat);
    end
    vectors++;
    if (exp_q.size() != 0 || exp_pc_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_leftover got csr=%0d pc=%0d required 0 0", name, exp_q.size(), exp_pc_q.size());
    end
    exp_q.delete();
    exp_pc_q.delete();
    bus.i_trap_pipe_empty = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if ({bus.o_trap_stall, bus.o_trap_flush, bus.o_trap_csr_we, bus.o_trap_pc_sel, bus.o_trap_busy} !== 5'b0 ||
        bus.o_trap_csr_addr !== 12'h0 || bus.o_trap_csr_wdata !== '0 || bus.o_trap_pc_target !== '0) begin
      miscompares++;
      $display("FAIL %s got stall=%b flush=%b we=%b sel=%b busy=%b addr=%h required all 0", name,
               bus.o_trap_stall, bus.o_trap_flush, bus.o_trap_csr_we, bus.o_trap_pc_sel,
               bus.o_trap_busy, bus.o_trap_csr_addr);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    clear_req();
    bus.i_trap_pc = '0;
    bus.i_trap_mtvec = '0;
    bus.i_trap_mepc = '0;
    bus.i_trap_mstatus = '0;
    bus.i_trap_pipe_empty = 1'b1;
    #2;
    check_all_zero("reset_async");
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_release");
  endtask

  task automatic test_ecall();
    set_csrs(64'h8000_0003, 64'h0, 64'h8);
    exp_q.push_back({12'h341, 64'h8000_0104});
    exp_q.push_back({12'h342, 64'd11});
    exp_q.push_back({12'h300, 64'h1880});
    exp_pc_q.push_back(64'h8000_0000);
    run_req(1, 0, 0, 64'h8000_0104, 5, 0, 0, "ecall");
  endtask

  task automatic test_mret();
    set_csrs(64'h8000_0003, 64'h8000_0109, 64'h80);
    exp_q.push_back({12'h300, 64'h1888});
    exp_pc_q.push_back(64'h8000_0108);
    run_req(0, 0, 1, 64'h8000_0200, 3, 0, 0, "mret");
  endtask

  task automatic test_drain();
    set_csrs(64'h4000_0101, 64'h0, 64'hF000_0000_0000_0008);
    exp_q.push_back({12'h341, 64'h1234});
    exp_q.push_back({12'h342, 64'd3});
    exp_q.push_back({12'h300, 64'hF000_0000_0000_1880});
    exp_pc_q.push_back(64'h4000_0100);
    run_req(0, 1, 0, 64'h1235, 8, 4, 0, "ebreak_drain");
  endtask

  task automatic test_priority();
    set_csrs(64'h3000_0002, 64'h5555, 64'h0);
    exp_q.push_back({12'h341, 64'h2000});
    exp_q.push_back({12'h342, 64'd3});
    exp_q.push_back({12'h300, 64'h1800});
    exp_pc_q.push_back(64'h3000_0000);
    run_req(1, 1, 0, 64'h2000, 5, 0, 1, "ecall_ebreak_busy");
    exp_q.push_back({12'h341, 64'h2010});
    exp_q.push_back({12'h342, 64'd3});
    exp_q.push_back({12'h300, 64'h1800});
    exp_pc_q.push_back(64'h3000_0000);
    run_req(1, 1, 1, 64'h2011, 5, 0, 0, "all_flags");
    exp_q.push_back({12'h341, 64'h2020});
    exp_q.push_back({12'h342, 64'd11});
    exp_q.push_back({12'h300, 64'h1800});
    exp_pc_q.push_back(64'h3000_0000);
    run_req(1, 0, 1, 64'h2020, 5, 0, 0, "ecall_mret");
  endtask

  task automatic test_no_valid();
    @(negedge clk);
    bus.i_trap_ecall  = 1'b1;
    bus.i_trap_ebreak = 1'b1;
    bus.i_trap_mret   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.i_trap_ebreak = 1'($urandom_range(0, 1));
      check_all_zero("no_valid");
    end
    clear_req();
  endtask

  task automatic test_reset_mid();
    set_csrs(64'h8000_0000, 64'h9000_0011, 64'h8);
    exp_q.push_back({12'h341, 64'h100});
    exp_q.push_back({12'h342, 64'd11});
    @(negedge clk);
    bus.i_trap_valid = 1'b1;
    bus.i_trap_ecall = 1'b1;
    bus.i_trap_pc    = 64'h100;
    @(negedge clk);
    clear_req();
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.o_trap_csr_addr !== 12'h342) begin
      miscompares++;
      $display("FAIL reset_mid_in_cause got addr=%h required 342", bus.o_trap_csr_addr);
    end
    #2 rst = 1'b1;
    #1 check_all_zero("reset_mid_async");
    @(negedge clk);
    check_all_zero("reset_mid_held");
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_writes got %0d pending required 0", exp_q.size());
    end
    // request presented as reset drops must be taken on the very next edge
    exp_q.push_back({12'h300, 64'h1880});
    exp_pc_q.push_back(64'h9000_0010);
    bus.i_trap_mstatus = 64'h8;
    rst = 1'b0;
    bus.i_trap_valid = 1'b1;
    bus.i_trap_mret  = 1'b1;
    bus.i_trap_pc    = 64'h300;
    @(negedge clk);
    clear_req();
    vectors++;
    if (bus.o_trap_busy !== 1'b1 || bus.dbg_state !== 3'd1) begin
      miscompares++;
      $display("FAIL first_edge_accept got busy=%b state=%0d required 1 1", bus.o_trap_busy, bus.dbg_state);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.o_trap_pc_sel !== 1'b1) begin
      miscompares++;
      $display("FAIL first_edge_latency got sel=%b required 1", bus.o_trap_pc_sel);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || exp_pc_q.size() != 0 || bus.o_trap_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL first_edge_done got csr=%0d pc=%0d busy=%b required 0 0 0",
               exp_q.size(), exp_pc_q.size(), bus.o_trap_busy);
    end
    exp_q.delete();
    exp_pc_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] pc;
    set_csrs(64'h8000_0004, 64'h8000_0040, 64'h0);
    for (int i = 0; i < 3; i++) begin
      pc = XLEN'($urandom_range(0, 32'hFFFF)) << 2;
      exp_q.push_back({12'h341, pc});
      exp_q.push_back({12'h342, 64'd11});
      exp_q.push_back({12'h300, 64'h1800});
      exp_pc_q.push_back(64'h8000_0004);
      run_req(1, 0, 0, pc, 5, 0, 0, "b2b_ecall");
      exp_q.push_back({12'h300, 64'h1880});
      exp_pc_q.push_back(64'h8000_0040);
      run_req(0, 0, 1, pc, 3, 0, 0, "b2b_mret");
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_ecall();
    test_mret();
    test_drain();
    test_priority();
    test_no_valid();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
